// File: rtl/apb2mem.sv
// apb2mem: APB4 completer that turns each APB transfer into one valid/ready memory-bus transaction.
// Optional response timeout is compiled in when APB2MEM_TIMEOUT_EN is defined.
module apb2mem #(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [31:0] apb_paddr_i,
  input  logic [2:0]  apb_pprot_i,
  input  logic        apb_psel_i,
  input  logic        apb_penable_i,
  input  logic        apb_pwrite_i,
  input  logic [31:0] apb_pwdata_i,
  input  logic [3:0]  apb_pstrb_i,
  output logic        apb_pready_o,
  output logic [31:0] apb_prdata_o,
  output logic        apb_pslverr_o,
  output logic        mem_valid_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic [3:0]  mem_wstrb_o,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_ready_i
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t      r_state;
  logic        r_abandon;
  logic        r_pready;
  logic [31:0] r_prdata;
  logic        r_pslverr;
  logic        r_mem_valid;
  logic [31:0] r_mem_addr;
  logic [31:0] r_mem_wdata;
  logic [3:0]  r_mem_wstrb;

  logic w_setup;
  logic w_misaligned;
  logic w_null_write;
  logic w_abandon;
  logic w_timeout;
  logic w_unused_pprot;

  assign w_setup        = apb_psel_i & ~apb_penable_i;
  assign w_misaligned   = (apb_paddr_i[1:0] != 2'b00);
  assign w_null_write   = apb_pwrite_i & (apb_pstrb_i == 4'b0000);
  // The initiator walked away mid-transfer if psel dropped at any point during REQ.
  assign w_abandon      = r_abandon | ~apb_psel_i;
  assign w_unused_pprot = ^apb_pprot_i;

`ifdef APB2MEM_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] r_cnt;

  // Terminal count is reached on the TIMEOUT_CYCLES-th unacknowledged REQ cycle; ready wins a tie.
  assign w_timeout = ~mem_ready_i & (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // Count REQ cycles without an acknowledge; cleared whenever not in REQ.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_cnt <= {CNT_W{1'b0}};
    end else if (r_state != ST_REQ) begin
      r_cnt <= {CNT_W{1'b0}};
    end else if (!mem_ready_i) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end else begin
      r_cnt <= r_cnt;
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  // Transfer FSM with all APB and memory-bus outputs registered.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_state     <= ST_IDLE;
      r_abandon   <= 1'b0;
      r_pready    <= 1'b0;
      r_prdata    <= 32'h0000_0000;
      r_pslverr   <= 1'b0;
      r_mem_valid <= 1'b0;
      r_mem_addr  <= 32'h0000_0000;
      r_mem_wdata <= 32'h0000_0000;
      r_mem_wstrb <= 4'b0000;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_pready  <= 1'b0;
          r_pslverr <= 1'b0;
          r_abandon <= 1'b0;
          if (w_setup) begin
            r_mem_addr  <= apb_paddr_i;
            r_mem_wdata <= apb_pwdata_i;
            r_mem_wstrb <= apb_pwrite_i ? apb_pstrb_i : 4'b0000;
            if (w_misaligned) begin
              r_pready  <= 1'b1;
              r_pslverr <= 1'b1;
              r_state   <= ST_RESP;
            end else if (w_null_write) begin
              r_pready  <= 1'b1;
              r_pslverr <= 1'b0;
              r_state   <= ST_RESP;
            end else begin
              r_mem_valid <= 1'b1;
              r_state     <= ST_REQ;
            end
          end
        end

        ST_REQ: begin
          if (!apb_psel_i) begin
            r_abandon <= 1'b1;
          end
          if (mem_ready_i) begin
            r_mem_valid <= 1'b0;
            r_prdata    <= (r_mem_wstrb == 4'b0000) ? mem_rdata_i : 32'h0000_0000;
            if (w_abandon) begin
              r_state <= ST_IDLE;
            end else begin
              r_pready  <= 1'b1;
              r_pslverr <= 1'b0;
              r_state   <= ST_RESP;
            end
          end else if (w_timeout) begin
            r_mem_valid <= 1'b0;
            r_prdata    <= 32'h0000_0000;
            if (w_abandon) begin
              r_state <= ST_IDLE;
            end else begin
              r_pready  <= 1'b1;
              r_pslverr <= 1'b1;
              r_state   <= ST_RESP;
            end
          end
        end

        ST_RESP: begin
          r_pready  <= 1'b0;
          r_pslverr <= 1'b0;
          r_state   <= ST_IDLE;
        end

        default: begin
          r_state     <= ST_IDLE;
          r_abandon   <= 1'b0;
          r_pready    <= 1'b0;
          r_pslverr   <= 1'b0;
          r_mem_valid <= 1'b0;
        end
      endcase
    end
  end

  assign apb_pready_o  = r_pready;
  assign apb_prdata_o  = r_prdata;
  assign apb_pslverr_o = r_pslverr;
  assign mem_valid_o   = r_mem_valid;
  assign mem_addr_o    = r_mem_addr;
  assign mem_wdata_o   = r_mem_wdata;
  assign mem_wstrb_o   = r_mem_wstrb;

endmodule

// File: tb/tb_apb2mem.sv
// Directed self-checking bench for apb2mem: normal, error, null-write, back-to-back,
// abandoned, reset-in-flight and (when APB2MEM_TIMEOUT_EN is defined) timeout transfers.
`timescale 1ns/1ps
module tb_apb2mem;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] paddr;
  logic [2:0]  pprot;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic        pready;
  logic [31:0] prdata;
  logic        pslverr;
  logic        mem_valid;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  always #5 clk = ~clk;

  apb2mem #(.TIMEOUT_CYCLES(8)) dut (
    .clk_i         (clk),
    .rst_n_i       (rst_n),
    .apb_paddr_i   (paddr),
    .apb_pprot_i   (pprot),
    .apb_psel_i    (psel),
    .apb_penable_i (penable),
    .apb_pwrite_i  (pwrite),
    .apb_pwdata_i  (pwdata),
    .apb_pstrb_i   (pstrb),
    .apb_pready_o  (pready),
    .apb_prdata_o  (prdata),
    .apb_pslverr_o (pslverr),
    .mem_valid_o   (mem_valid),
    .mem_addr_o    (mem_addr),
    .mem_wdata_o   (mem_wdata),
    .mem_wstrb_o   (mem_wstrb),
    .mem_rdata_i   (mem_rdata),
    .mem_ready_i   (mem_ready)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Observations from the most recent transfer.
  int          x_nvalid;
  int          x_pready_at;
  logic        x_err;
  logic [31:0] x_rdata;
  logic [31:0] x_addr;
  logic [31:0] x_wdata;
  logic [3:0]  x_wstrb;
  logic        x_valid_in_resp;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input string pfx);
    check({pfx, ".pready"},    {31'd0, pready},    32'd0);
    check({pfx, ".prdata"},    prdata,             32'd0);
    check({pfx, ".pslverr"},   {31'd0, pslverr},   32'd0);
    check({pfx, ".mem_valid"}, {31'd0, mem_valid}, 32'd0);
    check({pfx, ".mem_addr"},  mem_addr,           32'd0);
    check({pfx, ".mem_wdata"}, mem_wdata,          32'd0);
    check({pfx, ".mem_wstrb"}, {28'd0, mem_wstrb}, 32'd0);
  endtask

  // One APB transfer starting with its setup phase in the current cycle (T0).
  // rdy_at: memory acknowledges on the rdy_at-th cycle of mem_valid (0 = never).
  // Returns with the FSM back in IDLE; end_idle drops psel for one cycle afterwards.
  task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                      input logic [3:0] strb, input int rdy_at, input logic [31:0] rd,
                      input logic end_idle);
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wd; pstrb = strb;
    x_nvalid = 0; x_pready_at = -1; x_err = 1'b0; x_rdata = 32'd0;
    x_addr = 32'd0; x_wdata = 32'd0; x_wstrb = 4'd0; x_valid_in_resp = 1'b0;
    for (int c = 1; c <= 40 && x_pready_at < 0; c++) begin
      tick;
      penable   = 1'b1;
      mem_ready = 1'b0;
      if (mem_valid) begin
        x_nvalid++;
        x_addr = mem_addr; x_wdata = mem_wdata; x_wstrb = mem_wstrb;
        if (x_nvalid == rdy_at) begin
          mem_ready = 1'b1;
          mem_rdata = rd;
        end
      end
      if (pready) begin
        x_pready_at     = c;
        x_err           = pslverr;
        x_rdata         = prdata;
        x_valid_in_resp = mem_valid;
      end
    end
    mem_ready = 1'b0;
    tick;
    if (end_idle) begin
      psel = 1'b0; penable = 1'b0;
      tick;
    end
  endtask

  int   nv;
  logic seen_pready;

  initial begin
    rst_n = 1'b0; paddr = 32'd0; pprot = 3'd0; psel = 1'b0; penable = 1'b0;
    pwrite = 1'b0; pwdata = 32'd0; pstrb = 4'd0; mem_rdata = 32'd0; mem_ready = 1'b0;
    tick;
    tick;
    check_zero("reset");
    rst_n = 1'b1;
    tick;

    // Write, memory ready on the 2nd valid cycle.
    xfer(1'b1, 32'h0000_1000, 32'hDEAD_BEEF, 4'hF, 2, 32'h0, 1'b1);
    check("wr.nvalid",    x_nvalid,         32'd2);
    check("wr.pready_at", x_pready_at,      32'd3);
    check("wr.addr",      x_addr,           32'h0000_1000);
    check("wr.wdata",     x_wdata,          32'hDEAD_BEEF);
    check("wr.wstrb",     {28'd0, x_wstrb}, 32'hF);
    check("wr.pslverr",   {31'd0, x_err},   32'd0);
    check("wr.prdata",    x_rdata,          32'd0);
    check("wr.valid_resp", {31'd0, x_valid_in_resp}, 32'd0);

    // Read with immediate ready.
    xfer(1'b0, 32'h0000_2004, 32'h0, 4'hF, 1, 32'h1234_5678, 1'b1);
    check("rd.nvalid",    x_nvalid,         32'd1);
    check("rd.pready_at", x_pready_at,      32'd2);
    check("rd.addr",      x_addr,           32'h0000_2004);
    check("rd.wstrb",     {28'd0, x_wstrb}, 32'd0);
    check("rd.prdata",    x_rdata,          32'h1234_5678);
    check("rd.pslverr",   {31'd0, x_err},   32'd0);

    // Misaligned read: error, no memory access, prdata untouched.
    xfer(1'b0, 32'h0000_2002, 32'h0, 4'hF, 1, 32'hBAD0_BAD0, 1'b1);
    check("mis.nvalid",    x_nvalid,       32'd0);
    check("mis.pready_at", x_pready_at,    32'd1);
    check("mis.pslverr",   {31'd0, x_err}, 32'd1);
    check("mis.prdata",    x_rdata,        32'h1234_5678);

    // Null write: no memory access, no error.
    xfer(1'b1, 32'h0000_3000, 32'h0000_0055, 4'h0, 1, 32'h0, 1'b1);
    check("nul.nvalid",    x_nvalid,       32'd0);
    check("nul.pready_at", x_pready_at,    32'd1);
    check("nul.pslverr",   {31'd0, x_err}, 32'd0);

    // Back-to-back write then read, no idle cycle between.
    xfer(1'b1, 32'h0000_4000, 32'hA5A5_0F0F, 4'h3, 1, 32'h0, 1'b0);
    check("b2b.wr.pready_at", x_pready_at,      32'd2);
    check("b2b.wr.wdata",     x_wdata,          32'hA5A5_0F0F);
    check("b2b.wr.wstrb",     {28'd0, x_wstrb}, 32'h3);
    xfer(1'b0, 32'h0000_4000, 32'h0, 4'h0, 3, 32'h0F0F_A5A5, 1'b1);
    check("b2b.rd.nvalid",    x_nvalid,         32'd3);
    check("b2b.rd.pready_at", x_pready_at,      32'd4);
    check("b2b.rd.wstrb",     {28'd0, x_wstrb}, 32'd0);
    check("b2b.rd.prdata",    x_rdata,          32'h0F0F_A5A5);

`ifdef APB2MEM_TIMEOUT_EN
    // Memory never answers: abort after 8 valid cycles.
    xfer(1'b0, 32'h0000_5000, 32'h0, 4'h0, 0, 32'h0, 1'b1);
    check("to.nvalid",    x_nvalid,       32'd8);
    check("to.pready_at", x_pready_at,    32'd9);
    check("to.pslverr",   {31'd0, x_err}, 32'd1);
    check("to.prdata",    x_rdata,        32'd0);
    // Ready coincides with the terminal count: normal completion.
    xfer(1'b0, 32'h0000_5004, 32'h0, 4'h0, 8, 32'h600D_600D, 1'b1);
    check("to8.nvalid",    x_nvalid,       32'd8);
    check("to8.pready_at", x_pready_at,    32'd9);
    check("to8.pslverr",   {31'd0, x_err}, 32'd0);
    check("to8.prdata",    x_rdata,        32'h600D_600D);
`else
    // Without the timeout, a long wait still completes normally.
    xfer(1'b0, 32'h0000_5000, 32'h0, 4'h0, 20, 32'h600D_600D, 1'b1);
    check("long.nvalid",    x_nvalid,       32'd20);
    check("long.pready_at", x_pready_at,    32'd21);
    check("long.pslverr",   {31'd0, x_err}, 32'd0);
    check("long.prdata",    x_rdata,        32'h600D_600D);
`endif

    // psel dropped during REQ: memory access completes, no pready.
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 32'h0000_6000; pstrb = 4'h0;
    tick;
    check("drop.valid", {31'd0, mem_valid}, 32'd1);
    psel = 1'b0; penable = 1'b0;
    nv = 0; seen_pready = 1'b0;
    for (int c = 0; c < 6; c++) begin
      mem_ready = 1'b0;
      if (mem_valid) begin
        nv++;
        if (nv == 3) begin
          mem_ready = 1'b1;
          mem_rdata = 32'h0000_0077;
        end
      end
      if (pready) seen_pready = 1'b1;
      tick;
    end
    mem_ready = 1'b0;
    check("drop.nvalid", nv, 32'd3);
    check("drop.pready", {31'd0, seen_pready}, 32'd0);
    check("drop.valid_after", {31'd0, mem_valid}, 32'd0);

    // Reset asserted while in REQ.
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h0000_7000;
    pwdata = 32'h1122_3344; pstrb = 4'hF;
    tick;
    check("mrst.valid", {31'd0, mem_valid}, 32'd1);
    penable = 1'b1;
    rst_n = 1'b0;
    tick;
    check_zero("mrst");
    rst_n = 1'b1; psel = 1'b0; penable = 1'b0;
    tick;
    xfer(1'b0, 32'h0000_7008, 32'h0, 4'h0, 1, 32'h89AB_CDEF, 1'b1);
    check("post.nvalid",    x_nvalid,       32'd1);
    check("post.pready_at", x_pready_at,    32'd2);
    check("post.addr",      x_addr,         32'h0000_7008);
    check("post.prdata",    x_rdata,        32'h89AB_CDEF);
    check("post.pslverr",   {31'd0, x_err}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
